// File: rtl/radar_pio_pkg.sv
// radar_pio_pkg
// Shared constants and helpers for the radar PIO block.
//   - Avalon word addresses of the register map
//   - edge-capture mode encodings
//   - edge_vec(): per-bit edge vector from current and previous input samples
package radar_pio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_INPUT        = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Operates on 32-bit vectors so any WIDTH up to 32 can share it;
    // callers zero-extend inputs and truncate the result.
    function automatic logic [31:0] edge_vec(input int          mode,
                                             input logic [31:0] cur,
                                             input logic [31:0] prev);
        logic [31:0] result;
        case (mode)
            EDGE_RISING:  result = cur & ~prev;
            EDGE_FALLING: result = ~cur & prev;
            default:      result = cur ^ prev;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/radar_pio_sync.sv
// radar_pio_sync
// Input synchroniser and edge detector for the radar PIO.
//   clk, reset_n : clock, async active-low reset
//   in_port      : asynchronous external inputs
//   in_sync      : last synchroniser stage
//   edge_pulse   : one-cycle pulse per bit on the configured edge type
module radar_pio_sync
    import radar_pio_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] in_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            in_prev <= '0;
        end else begin
            chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            in_prev <= chain[SYNC_STAGES-1];
        end
    end

    assign in_sync    = chain[SYNC_STAGES-1];
    assign edge_pulse = WIDTH'(edge_vec(EDGE_TYPE, 32'(in_sync), 32'(in_prev)));

endmodule

// File: rtl/radar_pio_ext.sv
// radar_pio_ext
// Parametrised Avalon-MM GPIO slave: output register with atomic set/clear,
// synchronised input port, per-bit edge capture and maskable level irq.
//   clk, reset_n          : clock, async active-low reset
//   address, chipselect,
//   write_n, read_n,
//   writedata, readdata   : Avalon-MM slave, read latency 1
//   in_port               : asynchronous inputs
//   out_port              : output register
//   irq                   : registered level interrupt
module radar_pio_ext
    import radar_pio_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] cap_clear;
    logic [31:0]      rd_mux;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;
    assign wd    = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_wd_hi
            logic unused_wd_hi;
            assign unused_wd_hi = |writedata[31:WIDTH];
        end
    endgenerate

    radar_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_pulse (edge_pulse)
    );

    assign cap_clear = (wr_en && address == ADDR_EDGE_CAPTURE) ? wd : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:         rd_mux[WIDTH-1:0] = out_reg;
            ADDR_INPUT:        rd_mux[WIDTH-1:0] = in_sync;
            ADDR_IRQ_MASK:     rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
            default:           rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg      <= RESET_VALUE;
            irq_mask     <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
            readdata     <= '0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_DATA:     out_reg  <= wd;
                    ADDR_OUTSET:   out_reg  <= out_reg | wd;
                    ADDR_OUTCLEAR: out_reg  <= out_reg & ~wd;
                    ADDR_IRQ_MASK: irq_mask <= wd;
                    default:       ;
                endcase
            end
            // Clear applied before the OR so a coincident new edge survives.
            edge_capture <= (edge_capture & ~cap_clear) | edge_pulse;
            irq          <= |(edge_capture & irq_mask);
            if (rd_en) begin
                readdata <= rd_mux;
            end
        end
    end

    assign out_port = out_reg;

endmodule

// File: tb/tb_radar_pio_ext.sv
module tb_radar_pio_ext;

    localparam int            W       = 10;
    localparam logic [W-1:0]  RST_VAL = 10'h155;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic          read_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic [31:0]   readdata0, readdata1;
    logic [W-1:0]  out_port0, out_port1;
    logic          irq0, irq1;

    always #5 clk = ~clk;

    // Instance 0: rising edges, 2 sync stages. Instance 1: any edge, 3 stages.
    radar_pio_ext #(.WIDTH(W), .RESET_VALUE(RST_VAL), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata0),
        .in_port(in_port), .out_port(out_port0), .irq(irq0));

    radar_pio_ext #(.WIDTH(W), .RESET_VALUE(RST_VAL), .EDGE_TYPE(2), .SYNC_STAGES(3)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata1),
        .in_port(in_port), .out_port(out_port1), .irq(irq1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           stg  [2] = '{2, 3};
    int           mode [2] = '{0, 2};
    logic [W-1:0] m_out;
    logic [W-1:0] m_mask [2];
    logic [W-1:0] m_cap  [2];
    logic         m_irq  [2];
    logic [W-1:0] hist [$];      // in_port as sampled at each past clock edge
    logic [31:0]  exp_q0 [$];
    logic [31:0]  exp_q1 [$];
    logic         m_wr, m_rd;
    logic [W-1:0] m_wd, m_sync, m_prev, m_edge, m_clr;
    logic [31:0]  m_rv;

    function automatic logic [W-1:0] edge_of(input int md, input logic [W-1:0] cur,
                                             input logic [W-1:0] prev);
        if (md == 0) return cur & ~prev;
        if (md == 1) return ~cur & prev;
        return cur ^ prev;
    endfunction

    function automatic logic [31:0] read_value(input int i, input logic [2:0] a,
                                               input logic [W-1:0] sync_v);
        case (a)
            3'd0:    return 32'(m_out);
            3'd1:    return 32'(sync_v);
            3'd2:    return 32'(m_mask[i]);
            3'd3:    return 32'(m_cap[i]);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out = RST_VAL;
            hist.delete();
            repeat (5) hist.push_back('0);
            for (int i = 0; i < 2; i++) begin
                m_mask[i] = '0;
                m_cap[i]  = '0;
                m_irq[i]  = 1'b0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            m_wr  = chipselect && !write_n;
            m_rd  = chipselect && !read_n;
            m_wd  = writedata[W-1:0];
            m_clr = (m_wr && address == 3'd3) ? m_wd : '0;
            for (int i = 0; i < 2; i++) begin
                // in_sync lags in_port by stg[i] edges, in_prev by one more
                m_sync = hist[hist.size() - stg[i]];
                m_prev = hist[hist.size() - stg[i] - 1];
                m_edge = edge_of(mode[i], m_sync, m_prev);
                if (m_rd) begin
                    m_rv = read_value(i, address, m_sync);
                    if (i == 0) exp_q0.push_back(m_rv);
                    else        exp_q1.push_back(m_rv);
                end
                m_irq[i] = |(m_cap[i] & m_mask[i]);
                m_cap[i] = (m_cap[i] & ~m_clr) | m_edge;
                if (m_wr && address == 3'd2) m_mask[i] = m_wd;
            end
            if (m_wr) begin
                case (address)
                    3'd0:    m_out = m_wd;
                    3'd4:    m_out = m_out | m_wd;
                    3'd5:    m_out = m_out & ~m_wd;
                    default: ;
                endcase
            end
            hist.push_back(in_port);
            void'(hist.pop_front());
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_readdata0", readdata0, 32'd0);
            chk("rst_readdata1", readdata1, 32'd0);
        end else begin
            if (exp_q0.size() > 0) chk("readdata0", readdata0, exp_q0.pop_front());
            if (exp_q1.size() > 0) chk("readdata1", readdata1, exp_q1.pop_front());
        end
        chk("out_port0", 32'(out_port0), 32'(m_out));
        chk("out_port1", 32'(out_port1), 32'(m_out));
        chk("irq0", 32'(irq0), 32'(m_irq[0]));
        chk("irq1", 32'(irq1), 32'(m_irq[1]));
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        // 1. reset
        repeat (3) @(negedge clk);
        chk("reset_out", 32'(out_port0), 32'h155);
        chk("reset_irq", 32'(irq0), 32'd0);
        chk("reset_rd", readdata0, 32'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        bus_read(3'd2);
        chk("mask_after_reset", readdata0, 32'd0);

        // 2. set / clear
        bus_write(3'd0, 32'h0F0);      chk("data_write", 32'(out_port0), 32'h0F0);
        bus_write(3'd4, 32'h00F);      chk("outset", 32'(out_port0), 32'h0FF);
        bus_write(3'd5, 32'h0C0);      chk("outclear", 32'(out_port0), 32'h03F);
        bus_write(3'd0, 32'hFFFFF000); chk("data_hi_ignored", 32'(out_port0), 32'h000);

        // 3. rising capture and irq timing
        bus_write(3'd2, 32'h001);
        in_port[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("irq_not_yet", 32'(irq0), 32'd0);
        @(negedge clk);
        chk("irq_rise_c4", 32'(irq0), 32'd1);
        chk("irq_any_not_yet", 32'(irq1), 32'd0);
        @(negedge clk);
        chk("irq_any_c5", 32'(irq1), 32'd1);
        bus_write(3'd3, 32'h001);
        @(negedge clk);
        chk("irq_cleared", 32'(irq0), 32'd0);

        // 4. masked edge, then unmask
        bus_write(3'd2, 32'h000);
        in_port[5] = 1'b1;
        @(negedge clk);
        in_port[5] = 1'b0;
        repeat (6) @(negedge clk);
        chk("masked_no_irq", 32'(irq0), 32'd0);
        bus_read(3'd3);
        chk("masked_capture", readdata0, 32'h020);
        bus_write(3'd2, 32'h020);
        @(negedge clk);
        chk("unmask_irq", 32'(irq0), 32'd1);

        // 5. set-wins collision on bit 2, bit 3 cleared
        bus_write(3'd3, 32'h3FF);
        in_port[3] = 1'b1;
        repeat (5) @(negedge clk);
        in_port[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_write(3'd3, 32'h00C);      // lands on the edge that sets bit 2
        bus_read(3'd3);
        chk("set_wins", readdata0 & 32'h00C, 32'h004);

        // 6. any-edge, 3 stages: capture at cycle 4, re-capture after clear
        bus_write(3'd3, 32'h3FF);
        repeat (6) @(negedge clk);
        bus_write(3'd3, 32'h3FF);
        in_port[1] = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(3'd3);                // sampled at edge 4, before capture lands
        chk("any_before_c4", readdata1 & 32'h002, 32'h000);
        bus_read(3'd3);
        chk("any_after_c4", readdata1 & 32'h002, 32'h002);
        bus_write(3'd3, 32'h002);
        repeat (5) @(negedge clk);
        in_port[1] = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(3'd3);
        chk("any_recapture", readdata1 & 32'h002, 32'h002);
        chk("rise_ignores_fall", readdata0 & 32'h002, 32'h000);
        bus_read(3'd6);
        chk("reserved6", readdata0, 32'd0);
        bus_read(3'd7);
        chk("reserved7", readdata1, 32'd0);

        // random traffic with a mid-run reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #3 reset_n = 1'b0;
                repeat (2) @(negedge clk);
                #2 reset_n = 1'b1;
            end
            op = int'($urandom_range(0, 3));
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            chipselect = (op != 0);
            write_n    = !(op == 1 || op == 3);
            read_n     = !(op == 2 || op == 3);
            if ($urandom_range(0, 3) == 0)
                in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
            @(negedge clk);
        end
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
